// File: rtl/pc_pkg.sv
// Shared definitions for the program-counter sequencer.
// Holds the operation encodings decoded by pc_sequencer and the op field width.
package pc_pkg;

  localparam int unsigned PC_OP_W = 3;

  typedef logic [PC_OP_W-1:0] pc_op_t;

  localparam pc_op_t PC_HOLD = 3'b000;
  localparam pc_op_t PC_INC  = 3'b001;
  localparam pc_op_t PC_JMP  = 3'b010;
  localparam pc_op_t PC_BRA  = 3'b011;
  localparam pc_op_t PC_CALL = 3'b100;
  localparam pc_op_t PC_RET  = 3'b101;
  // 3'b110 and 3'b111 are reserved and behave as PC_HOLD.

endpackage

// File: rtl/pc_stack.sv
// Return-address LIFO for pc_sequencer.
// Ports:
//   clk, clrbar   clock and synchronous active-low reset (clears the count only)
//   push, pop     request one push or one pop; ignored when full / empty
//   din           value to push
//   dout          current top-of-stack (valid only while !empty)
//   count         number of valid entries
//   full, empty   count == STACK_DEPTH / count == 0
module pc_stack #(
  parameter int unsigned WIDTH       = 16,
  parameter int unsigned STACK_DEPTH = 4,
  parameter int unsigned SPW         = $clog2(STACK_DEPTH + 1)
) (
  input  logic             clk,
  input  logic             clrbar,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout,
  output logic [SPW-1:0]   count,
  output logic             full,
  output logic             empty
);

  // Index width; storage is rounded up to a power of two so every index value is in range.
  localparam int unsigned AW = (STACK_DEPTH > 1) ? $clog2(STACK_DEPTH) : 1;

  logic [WIDTH-1:0] mem_q [2**AW];
  logic [SPW-1:0]   count_q;
  logic [SPW-1:0]   count_m1;
  logic [AW-1:0]    wr_idx;
  logic [AW-1:0]    rd_idx;

  assign count    = count_q;
  assign full     = (count_q == SPW'(STACK_DEPTH));
  assign empty    = (count_q == '0);
  assign count_m1 = count_q - SPW'(1);
  assign wr_idx   = count_q[AW-1:0];
  assign rd_idx   = count_m1[AW-1:0];
  assign dout     = mem_q[rd_idx];

  always_ff @(posedge clk) begin
    if (!clrbar) begin
      count_q <= '0;
    end else if (push && !full) begin
      count_q <= count_q + SPW'(1);
    end else if (pop && !empty) begin
      count_q <= count_q - SPW'(1);
    end
  end

  // Storage is deliberately not reset; entries above count are never read.
  always_ff @(posedge clk) begin
    if (clrbar && push && !full) begin
      mem_q[wr_idx] <= din;
    end
  end

endmodule

// File: rtl/pc_sequencer.sv
// Program-counter sequencer: hold / increment / jump / relative branch / call / return.
// Ports:
//   clk, clrbar   clock and synchronous active-low reset
//   op            operation select (pc_pkg encodings; reserved codes hold)
//   cond          take JMP/BRA/CALL when 1
//   d             jump target or signed branch offset
//   q             current program counter (registered)
//   sp            number of valid return-stack entries
//   ovf, unf      sticky CALL-overflow / RET-underflow flags, cleared only by reset
module pc_sequencer
  import pc_pkg::*;
#(
  parameter int unsigned     WIDTH        = 16,
  parameter int unsigned     STACK_DEPTH  = 4,
  parameter logic [WIDTH-1:0] RESET_VECTOR = '0,
  parameter int unsigned     SPW          = $clog2(STACK_DEPTH + 1)
) (
  input  logic               clk,
  input  logic               clrbar,
  input  logic [PC_OP_W-1:0] op,
  input  logic               cond,
  input  logic [WIDTH-1:0]   d,
  output logic [WIDTH-1:0]   q,
  output logic [SPW-1:0]     sp,
  output logic               ovf,
  output logic               unf
);

  logic [WIDTH-1:0] q_q, q_d;
  logic             ovf_q, ovf_d;
  logic             unf_q, unf_d;
  logic [WIDTH-1:0] addend;
  logic [WIDTH-1:0] sum;
  logic             push, pop;
  logic [WIDTH-1:0] top;
  logic             full, empty;

  // One adder serves INC, BRA and the CALL return address; only a taken BRA adds d.
  assign addend = (op == PC_BRA && cond) ? d : WIDTH'(1);
  assign sum    = q_q + addend;

  always_comb begin
    q_d   = q_q;
    ovf_d = ovf_q;
    unf_d = unf_q;
    push  = 1'b0;
    pop   = 1'b0;
    case (op)
      PC_INC: q_d = sum;
      PC_JMP: q_d = cond ? d : sum;
      PC_BRA: q_d = sum;
      PC_CALL: begin
        if (cond && !full) begin
          push = 1'b1;
          q_d  = d;
        end else begin
          q_d = sum;
          if (cond) ovf_d = 1'b1;
        end
      end
      PC_RET: begin
        if (!empty) begin
          pop = 1'b1;
          q_d = top;
        end else begin
          q_d   = sum;
          unf_d = 1'b1;
        end
      end
      default: ;
    endcase
  end

  always_ff @(posedge clk) begin
    if (!clrbar) begin
      q_q   <= RESET_VECTOR;
      ovf_q <= 1'b0;
      unf_q <= 1'b0;
    end else begin
      q_q   <= q_d;
      ovf_q <= ovf_d;
      unf_q <= unf_d;
    end
  end

  pc_stack #(
    .WIDTH       (WIDTH),
    .STACK_DEPTH (STACK_DEPTH),
    .SPW         (SPW)
  ) u_stack (
    .clk    (clk),
    .clrbar (clrbar),
    .push   (push),
    .pop    (pop),
    .din    (sum),
    .dout   (top),
    .count  (sp),
    .full   (full),
    .empty  (empty)
  );

  assign q   = q_q;
  assign ovf = ovf_q;
  assign unf = unf_q;

endmodule

// File: tb/tb_pc_sequencer.sv
module tb_pc_sequencer;

  logic        clk = 1'b0;
  logic        clrbar;
  logic [2:0]  op;
  logic        cond;
  logic [15:0] d;
  logic [15:0] q;
  logic [2:0]  sp;
  logic        ovf, unf;

  int tests = 0;
  int fails = 0;

  always #5 clk = ~clk;

  pc_sequencer #(
    .WIDTH        (16),
    .STACK_DEPTH  (4),
    .RESET_VECTOR (16'h0100)
  ) dut (
    .clk    (clk),
    .clrbar (clrbar),
    .op     (op),
    .cond   (cond),
    .d      (d),
    .q      (q),
    .sp     (sp),
    .ovf    (ovf),
    .unf    (unf)
  );

  // Apply inputs, take one rising edge, sample 1 time unit later.
  task automatic step(input logic [2:0] o, input logic c, input logic [15:0] dv);
    op   = o;
    cond = c;
    d    = dv;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %h expected %h", tag, obs, exp);
    end
  endtask

  task automatic check_state(input string tag, input logic [15:0] eq, input logic [2:0] esp,
                             input logic eo, input logic eu);
    check({tag, ".q"},   32'(q),   32'(eq));
    check({tag, ".sp"},  32'(sp),  32'(esp));
    check({tag, ".ovf"}, 32'(ovf), 32'(eo));
    check({tag, ".unf"}, 32'(unf), 32'(eu));
  endtask

  initial begin
    clrbar = 1'b1;
    op     = 3'b000;
    cond   = 1'b0;
    d      = '0;
    @(negedge clk);

    // Reset overrides INC
    clrbar = 1'b0;
    step(3'b001, 1'b0, 16'h0000);
    check_state("reset", 16'h0100, 3'd0, 1'b0, 1'b0);
    clrbar = 1'b1;
    step(3'b001, 1'b0, 16'h0000);
    step(3'b001, 1'b0, 16'h0000);
    step(3'b001, 1'b0, 16'h0000);
    check("inc3", 32'(q), 32'h0103);
    step(3'b010, 1'b0, 16'hAAAA);
    check("jmp_not_taken", 32'(q), 32'h0104);

    // Wrap
    step(3'b010, 1'b1, 16'hFFFE);
    check("jmp_fffe", 32'(q), 32'hFFFE);
    step(3'b001, 1'b0, 16'h0000);
    check("inc_ffff", 32'(q), 32'hFFFF);
    step(3'b001, 1'b0, 16'h0000);
    check("inc_wrap", 32'(q), 32'h0000);

    // Relative branch
    step(3'b010, 1'b1, 16'h0010);
    step(3'b011, 1'b1, 16'hFFFC);
    check("bra_back4", 32'(q), 32'h000C);
    step(3'b011, 1'b0, 16'hFFFC);
    check("bra_not_taken", 32'(q), 32'h000D);

    // Nested call/return
    step(3'b010, 1'b1, 16'h0200);
    step(3'b100, 1'b1, 16'h1000);
    check_state("call1", 16'h1000, 3'd1, 1'b0, 1'b0);
    step(3'b100, 1'b1, 16'h2000);
    check_state("call2", 16'h2000, 3'd2, 1'b0, 1'b0);
    step(3'b101, 1'b0, 16'h0000);
    check_state("ret1", 16'h1001, 3'd1, 1'b0, 1'b0);
    step(3'b101, 1'b1, 16'h0000);
    check_state("ret2", 16'h0201, 3'd0, 1'b0, 1'b0);
    step(3'b100, 1'b0, 16'h3000);
    check_state("call_not_taken", 16'h0202, 3'd0, 1'b0, 1'b0);

    // Overflow at depth 4
    step(3'b100, 1'b1, 16'h3000);
    step(3'b100, 1'b1, 16'h4000);
    step(3'b100, 1'b1, 16'h5000);
    check_state("call3", 16'h5000, 3'd3, 1'b0, 1'b0);
    step(3'b100, 1'b1, 16'h6000);
    check_state("call4_full", 16'h6000, 3'd4, 1'b0, 1'b0);
    step(3'b100, 1'b1, 16'h7000);
    check_state("call5_ovf", 16'h6001, 3'd4, 1'b1, 1'b0);
    step(3'b101, 1'b0, 16'h0000);
    check_state("ovf_ret1", 16'h5001, 3'd3, 1'b1, 1'b0);
    step(3'b101, 1'b0, 16'h0000);
    check_state("ovf_ret2", 16'h4001, 3'd2, 1'b1, 1'b0);
    step(3'b101, 1'b0, 16'h0000);
    check_state("ovf_ret3", 16'h3001, 3'd1, 1'b1, 1'b0);
    step(3'b101, 1'b0, 16'h0000);
    check_state("ovf_ret4", 16'h0203, 3'd0, 1'b1, 1'b0);

    // Underflow and reserved ops
    step(3'b010, 1'b1, 16'h0050);
    step(3'b101, 1'b0, 16'h0000);
    check_state("unf", 16'h0051, 3'd0, 1'b1, 1'b1);
    step(3'b111, 1'b1, 16'h9999);
    check("rsv111_hold", 32'(q), 32'h0051);
    step(3'b110, 1'b1, 16'h9999);
    check("rsv110_hold", 32'(q), 32'h0051);
    step(3'b000, 1'b1, 16'h9999);
    check_state("hold", 16'h0051, 3'd0, 1'b1, 1'b1);

    // Reset mid-chain
    step(3'b100, 1'b1, 16'h0800);
    step(3'b100, 1'b1, 16'h0900);
    check_state("chain2", 16'h0900, 3'd2, 1'b1, 1'b1);
    clrbar = 1'b0;
    step(3'b101, 1'b0, 16'h0000);
    check_state("reset_mid", 16'h0100, 3'd0, 1'b0, 1'b0);
    clrbar = 1'b1;
    step(3'b101, 1'b0, 16'h0000);
    check_state("ret_after_reset", 16'h0101, 3'd0, 1'b0, 1'b1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
